// File: rtl/c1541_track_ctrl.sv
// Head stepper decode, half-track position and track-buffer load/save sequencing
// towards the SD loader for the 1541 drive core.
module c1541_track_ctrl #(
    parameter int SETTLE_CYC = 32000,
    parameter int MAX_HT     = 83
) (
    input  logic       clk32,
    input  logic       reset_n,
    input  logic [1:0] stp,
    input  logic       mtr,
    input  logic       wr_strobe,
    input  logic       disk_change,
    input  logic       ld_ack,
    output logic       ld_req,
    output logic       ld_we,
    output logic [5:0] ld_track,
    output logic [6:0] half_track,
    output logic       tr00_sense_n,
    output logic       busy,
    output logic       dirty
);

    localparam int CW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAVE, LOAD} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic [1:0]    stp_q;
    logic          mtr_q;
    logic [5:0]    loaded_track;
    logic          loaded_vld;
    logic          save_only;
    logic          step_in, step_out, step, mtr_fall;

    // No reset: stp_q follows stp during reset so no phase edge is seen on release.
    always_ff @(posedge clk32) stp_q <= stp;

    assign step_in  = mtr && (stp == 2'(stp_q + 2'd1));
    assign step_out = mtr && (stp == 2'(stp_q - 2'd1));
    assign step     = step_in | step_out;
    assign mtr_fall = mtr_q & ~mtr;

    assign busy         = (state != IDLE);
    assign tr00_sense_n = (half_track != 7'd0);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (mtr_fall && dirty)
                    state_d = SAVE;
                else if (!loaded_vld || half_track[6:1] != loaded_track)
                    state_d = SETTLE;
            end
            SETTLE: begin
                if (!step && cnt <= CW'(1))
                    state_d = (dirty && loaded_vld) ? SAVE : LOAD;
            end
            SAVE: if (ld_ack) state_d = save_only ? IDLE : LOAD;
            LOAD: if (ld_ack) state_d = IDLE;
        endcase
        if (disk_change) state_d = SETTLE;
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= SETTLE;
            cnt          <= CW'(SETTLE_CYC);
            half_track   <= 7'd34;
            dirty        <= 1'b0;
            ld_req       <= 1'b0;
            ld_we        <= 1'b0;
            ld_track     <= 6'd17;
            loaded_track <= 6'd0;
            loaded_vld   <= 1'b0;
            save_only    <= 1'b0;
            mtr_q        <= 1'b0;
        end else begin
            state <= state_d;
            mtr_q <= mtr;

            if (step_in && half_track < 7'(MAX_HT))
                half_track <= half_track + 7'd1;
            else if (step_out && half_track != 7'd0)
                half_track <= half_track - 7'd1;

            if (step || disk_change || (state != SETTLE && state_d == SETTLE))
                cnt <= CW'(SETTLE_CYC);
            else if (state == SETTLE && cnt != '0)
                cnt <= cnt - CW'(1);

            // Request lags state entry by a cycle and drops right after ack.
            ld_req <= (state == SAVE || state == LOAD) && !ld_ack && !disk_change;

            if (state_d == SAVE && state != SAVE) begin
                ld_we     <= 1'b1;
                ld_track  <= loaded_track;
                save_only <= (state == IDLE);
            end
            if (state_d == LOAD && state != LOAD) begin
                ld_we    <= 1'b0;
                ld_track <= half_track[6:1];
            end

            if (disk_change)
                loaded_vld <= 1'b0;
            else if (state == LOAD && ld_ack) begin
                loaded_track <= ld_track;
                loaded_vld   <= 1'b1;
            end

            if (disk_change)
                dirty <= 1'b0;
            else if (wr_strobe && state != LOAD)
                dirty <= 1'b1;
            else if (state == SAVE && ld_ack)
                dirty <= 1'b0;
        end
    end

endmodule

// File: tb/tb_c1541_track_ctrl.sv
// Directed bench for c1541_track_ctrl with a shortened settle time.
module tb_c1541_track_ctrl;

    localparam int N = 200;

    logic       clk32 = 1'b0;
    logic       reset_n;
    logic [1:0] stp;
    logic       mtr, wr_strobe, disk_change, ld_ack;
    logic       ld_req, ld_we, tr00_sense_n, busy, dirty;
    logic [5:0] ld_track;
    logic [6:0] half_track;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    logic [1:0] ph;

    c1541_track_ctrl #(.SETTLE_CYC(N), .MAX_HT(83)) dut (
        .clk32(clk32), .reset_n(reset_n), .stp(stp), .mtr(mtr),
        .wr_strobe(wr_strobe), .disk_change(disk_change), .ld_ack(ld_ack),
        .ld_req(ld_req), .ld_we(ld_we), .ld_track(ld_track),
        .half_track(half_track), .tr00_sense_n(tr00_sense_n),
        .busy(busy), .dirty(dirty)
    );

    always #5 clk32 = ~clk32;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk32);
            #1;
        end
    endtask

    task automatic wait_req(input string tag, input int max_cyc, output int l);
        l = 0;
        while (!ld_req && l < max_cyc) begin
            tick();
            l++;
        end
        chk(tag, ld_req, 1);
    endtask

    // ld_ack three cycles after ld_req was seen; ld_req must drop right after.
    task automatic serve(input string tag);
        tick(2);
        ld_ack = 1'b1;
        tick();
        ld_ack = 1'b0;
        chk(tag, ld_req, 0);
    endtask

    task automatic quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            tick();
            if (ld_req) seen = 1'b1;
        end
        chk(tag, seen, 0);
    endtask

    task automatic pulse_wr();
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; stp = 2'd0; mtr = 1'b0;
        wr_strobe = 1'b0; disk_change = 1'b0; ld_ack = 1'b0;
        ph = 2'd0;
        tick(3);
        chk("rst half_track", half_track, 34);
        chk("rst ld_track", ld_track, 17);
        chk("rst busy", busy, 1);
        chk("rst ld_req", ld_req, 0);
        chk("rst ld_we", ld_we, 0);
        chk("rst dirty", dirty, 0);
        chk("rst tr00", tr00_sense_n, 1);

        // First transfer after reset: LOAD of track 17
        reset_n = 1'b1;
        wait_req("boot req", N + 10, lat);
        chk("boot latency", lat, N + 1);
        chk("boot we", ld_we, 0);
        chk("boot track", ld_track, 17);
        pulse_wr();
        chk("wr in LOAD ignored", dirty, 0);
        serve("boot req drop");
        tick(2);
        chk("boot idle", busy, 0);

        // Three inward steps 34 -> 37, then LOAD of track 18
        mtr = 1'b1;
        tick(2);
        stp = 2'd1; tick(100);
        stp = 2'd2;
        quiet("no req while stepping", 100);
        stp = 2'd3;
        wait_req("t18 req", N + 10, lat);
        chk("t18 latency", lat, N + 2);
        chk("t18 half_track", half_track, 37);
        chk("t18 we", ld_we, 0);
        chk("t18 track", ld_track, 18);
        serve("t18 req drop");
        tick(2);
        chk("t18 idle", busy, 0);

        // Dirty buffer then two inward steps: SAVE 18 followed by LOAD 19
        pulse_wr();
        chk("dirty set", dirty, 1);
        stp = 2'd0; tick(10);
        stp = 2'd1;
        wait_req("save18 req", N + 10, lat);
        chk("save18 latency", lat, N + 2);
        chk("save18 we", ld_we, 1);
        chk("save18 track", ld_track, 18);
        serve("save18 req drop");
        chk("dirty cleared", dirty, 0);
        wait_req("load19 req", 5, lat);
        chk("load19 latency", lat, 1);
        chk("load19 we", ld_we, 0);
        chk("load19 track", ld_track, 19);
        serve("load19 req drop");
        chk("half 39", half_track, 39);

        // Step out to half-track 0, saturation and 2-phase jumps
        ph = 2'd1;
        for (int i = 0; i < 38; i++) begin
            ph = ph - 2'd1; stp = ph; tick(2);
        end
        chk("half 1", half_track, 1);
        chk("tr00 off at 1", tr00_sense_n, 1);
        ph = ph - 2'd1; stp = ph; tick(2);
        chk("half 0", half_track, 0);
        chk("tr00 at 0", tr00_sense_n, 0);
        for (int i = 0; i < 2; i++) begin
            ph = ph - 2'd1; stp = ph; tick(2);
        end
        chk("half 0 saturated", half_track, 0);
        ph = ph + 2'd2; stp = ph; tick(2);
        chk("2-phase jump ignored", half_track, 0);
        mtr = 1'b0;
        ph = ph + 2'd1; stp = ph; tick(3);
        chk("motor off step ignored", half_track, 0);
        mtr = 1'b1; tick(3);
        chk("motor on no step", half_track, 0);
        wait_req("t0 req", 2 * N + 10, lat);
        chk("t0 we", ld_we, 0);
        chk("t0 track", ld_track, 0);
        serve("t0 req drop");
        tick(2);
        chk("t0 idle", busy, 0);

        // Motor off with dirty buffer in IDLE: immediate SAVE, no LOAD after
        pulse_wr();
        chk("dirty before mtr off", dirty, 1);
        chk("idle before mtr off", busy, 0);
        mtr = 1'b0;
        wait_req("mtr-off save req", 10, lat);
        chk("mtr-off save latency", lat, 2);
        chk("mtr-off save we", ld_we, 1);
        chk("mtr-off save track", ld_track, 0);
        serve("mtr-off req drop");
        chk("mtr-off dirty", dirty, 0);
        quiet("no load after mtr-off save", N + 20);
        chk("mtr-off idle", busy, 0);

        // disk_change and ld_ack together during SAVE: disk_change wins
        mtr = 1'b1; tick(2);
        pulse_wr();
        mtr = 1'b0;
        wait_req("dc save req", 10, lat);
        chk("dc save we", ld_we, 1);
        tick(2);
        ld_ack = 1'b1; disk_change = 1'b1;
        tick();
        ld_ack = 1'b0; disk_change = 1'b0;
        chk("dc req drop", ld_req, 0);
        chk("dc dirty", dirty, 0);
        chk("dc busy", busy, 1);
        wait_req("dc load req", N + 10, lat);
        chk("dc load latency", lat, N + 1);
        chk("dc load we", ld_we, 0);
        chk("dc load track", ld_track, 0);
        serve("dc load req drop");
        tick(2);
        chk("dc idle", busy, 0);

        // Reset while a request is outstanding drops it at once
        reset_n = 1'b0; tick(2);
        reset_n = 1'b1;
        wait_req("rst2 req", N + 10, lat);
        chk("rst2 latency", lat, N + 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst mid-xfer ld_req", ld_req, 0);
        chk("rst mid-xfer half", half_track, 34);
        chk("rst mid-xfer busy", busy, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
